// File: rtl/uart_rx_ext.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ext
// Description : 16x-oversampled UART receiver with a configurable frame
//               format (5..8 data bits, optional even/odd parity, LSB/MSB
//               first, selectable line polarity), break / framing / parity
//               detection and a first-word fall-through receive FIFO.
//               Optional feature macro: UART_RX_TIMEOUT_EN enables the
//               receive idle timeout; when undefined timeout_o is tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ext #(
    parameter int FIFO_AW       = 4,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               msb_first_i,
    input  logic               parity_en_i,
    input  logic               parity_odd_i,
    input  logic [1:0]         data_bits_i,
    input  logic               start_polarity_i,
    input  logic               serial_in_i,
    input  logic               en_16x_baud_i,
    input  logic               read_buffer_i,
    input  logic               reset_buffer_i,
    output logic [7:0]         data_out_o,
    output logic [2:0]         err_out_o,
    output logic [FIFO_AW:0]   buffer_level_o,
    output logic               buffer_data_present_o,
    output logic               buffer_full_o,
    output logic               buffer_hfull_o,
    output logic               overrun_o,
    output logic               timeout_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 c_DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   c_LVL_FULL = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   c_LVL_HALF = c_LVL_FULL >> 1;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic                r_sync1;
    logic                r_sync2;
    logic                w_bit;        // normalized line: 0 = start level
    logic                w_mid;        // tick that lands on a bit centre

    logic [2:0]          r_state;
    logic [3:0]          r_tick_cnt;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_data;
    logic                r_all_start;  // every sample so far was at start level
    logic                r_par_err;
    logic                r_brk_hold;   // after a break, wait for idle level

    logic [2:0]          w_nbits_m1;
    logic [2:0]          w_bit_pos;

    logic                r_wr_valid;
    logic [7:0]          r_wr_data;
    logic [2:0]          r_wr_err;

    logic [10:0]         r_mem [c_DEPTH];
    logic [FIFO_AW-1:0]  r_wr_ptr;
    logic [FIFO_AW-1:0]  r_rd_ptr;
    logic [FIFO_AW:0]    r_level;
    logic                r_overrun;
    logic                w_full;
    logic                w_empty;
    logic                w_do_rd;
    logic                w_do_wr;
    logic [10:0]         w_head;

    // ------------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------------
    // Two-flop synchronizer; resets to 1 so a line idling low after reset
    // (inverse polarity) looks like a start that the mid-bit check rejects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= serial_in_i;
            r_sync2 <= r_sync1;
        end
    end

    // Folding the polarity in here lets the rest of the receiver treat the
    // line as "0 = start/space, 1 = stop/mark" regardless of configuration.
    assign w_bit      = r_sync2 ^ start_polarity_i;
    assign w_mid      = (r_tick_cnt == 4'd15);
    assign w_nbits_m1 = {1'b1, data_bits_i};          // 4..7 = N-1
    assign w_bit_pos  = msb_first_i ? (w_nbits_m1 - r_bit_cnt) : r_bit_cnt;

    // Frame FSM: start qualification, data/parity/stop sampling, char hand-off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_tick_cnt  <= 4'd0;
            r_bit_cnt   <= 3'd0;
            r_data      <= 8'd0;
            r_all_start <= 1'b0;
            r_par_err   <= 1'b0;
            r_brk_hold  <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_wr_data   <= 8'd0;
            r_wr_err    <= 3'd0;
        end else begin
            r_wr_valid <= 1'b0;
            if (en_16x_baud_i) begin
                case (r_state)
                    c_IDLE: begin
                        r_tick_cnt <= 4'd0;
                        if (r_brk_hold) begin
                            // A break would otherwise re-trigger endlessly
                            // while the line stays at start level.
                            if (w_bit) begin
                                r_brk_hold <= 1'b0;
                            end
                        end else if (!w_bit) begin
                            r_state <= c_START;
                        end
                    end
                    c_START: begin
                        if (r_tick_cnt == 4'd7) begin
                            r_tick_cnt <= 4'd0;
                            if (!w_bit) begin
                                r_state     <= c_DATA;
                                r_bit_cnt   <= 3'd0;
                                r_data      <= 8'd0;
                                r_all_start <= 1'b1;
                                r_par_err   <= 1'b0;
                            end else begin
                                r_state <= c_IDLE;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 4'd1;
                        end
                    end
                    c_DATA: begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                        if (w_mid) begin
                            r_data[w_bit_pos] <= w_bit;
                            r_all_start       <= r_all_start & ~w_bit;
                            if (r_bit_cnt == w_nbits_m1) begin
                                r_state <= parity_en_i ? c_PARITY : c_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                    c_PARITY: begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                        if (w_mid) begin
                            // Unused data MSBs were cleared, so a full-width
                            // reduction covers exactly the received bits.
                            r_par_err   <= (^r_data) ^ w_bit ^ parity_odd_i;
                            r_all_start <= r_all_start & ~w_bit;
                            r_state     <= c_STOP;
                        end
                    end
                    c_STOP: begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                        if (w_mid) begin
                            r_state    <= c_IDLE;
                            r_wr_valid <= 1'b1;
                            if (r_all_start && !w_bit) begin
                                r_wr_data  <= 8'd0;
                                r_wr_err   <= 3'b110;
                                r_brk_hold <= 1'b1;
                            end else begin
                                r_wr_data <= r_data;
                                r_wr_err  <= {1'b0, ~w_bit, r_par_err};
                            end
                        end
                    end
                    default: begin
                        r_state    <= c_IDLE;
                        r_tick_cnt <= 4'd0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Receive FIFO (first-word fall-through)
    // ------------------------------------------------------------------------
    assign w_full  = (r_level == c_LVL_FULL);
    assign w_empty = (r_level == '0);
    assign w_do_rd = read_buffer_i && !w_empty;
    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_wr = r_wr_valid && (!w_full || w_do_rd);
    assign w_head  = r_mem[r_rd_ptr];

    // Storage array; contents need no reset because outputs are gated by level.
    always_ff @(posedge clk) begin
        if (w_do_wr && !reset_buffer_i) begin
            r_mem[r_wr_ptr] <= {r_wr_data, r_wr_err};
        end
    end

    // Pointer, level and sticky overrun bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_overrun <= 1'b0;
        end else if (reset_buffer_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (r_wr_valid && !w_do_wr) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign data_out_o            = w_empty ? 8'd0 : w_head[10:3];
    assign err_out_o             = w_empty ? 3'd0 : w_head[2:0];
    assign buffer_level_o        = r_level;
    assign buffer_data_present_o = !w_empty;
    assign buffer_full_o         = w_full;
    assign buffer_hfull_o        = (r_level >= c_LVL_HALF);
    assign overrun_o             = r_overrun;

    // ------------------------------------------------------------------------
    // Receive idle timeout
    // ------------------------------------------------------------------------
`ifdef UART_RX_TIMEOUT_EN
    localparam int                  c_TO_TICKS = TIMEOUT_CHARS * 160;
    localparam int                  c_TO_W     = $clog2(c_TO_TICKS + 1);
    localparam logic [c_TO_W-1:0]   c_TO_LAST  = c_TO_W'(c_TO_TICKS - 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_timeout;

    // Counts idle ticks while unread data sits in the FIFO; any FIFO
    // activity restarts the measurement and withdraws the timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (reset_buffer_i || w_do_rd || w_do_wr) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (en_16x_baud_i && (r_state == c_IDLE) && !w_empty
                     && !r_timeout) begin
            if (r_to_cnt == c_TO_LAST) begin
                r_timeout <= 1'b1;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    assign timeout_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ext.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ext
// Description : Self-checking bench for uart_rx_ext. Frames are driven as
//               bit-level waveforms; expected FIFO entries are queued when a
//               frame is driven and compared as the FIFO is read back.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ext;

    localparam int FIFO_AW = 4;
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int TDIV    = 2;                 // clocks per 16x tick
    localparam int BITCLK  = 16 * TDIV;         // clocks per bit

    logic             clk;
    logic             rst;
    logic             msb_first_i;
    logic             parity_en_i;
    logic             parity_odd_i;
    logic [1:0]       data_bits_i;
    logic             start_polarity_i;
    logic             serial_in_i;
    logic             en_16x_baud_i;
    logic             read_buffer_i;
    logic             reset_buffer_i;
    logic [7:0]       data_out_o;
    logic [2:0]       err_out_o;
    logic [FIFO_AW:0] buffer_level_o;
    logic             buffer_data_present_o;
    logic             buffer_full_o;
    logic             buffer_hfull_o;
    logic             overrun_o;
    logic             timeout_o;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] e;
    } exp_t;

    exp_t exp_q[$];
    logic exp_ovr;
    int   n_cmp;
    int   n_err;

    uart_rx_ext #(.FIFO_AW(FIFO_AW), .TIMEOUT_CHARS(4)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .msb_first_i           (msb_first_i),
        .parity_en_i           (parity_en_i),
        .parity_odd_i          (parity_odd_i),
        .data_bits_i           (data_bits_i),
        .start_polarity_i      (start_polarity_i),
        .serial_in_i           (serial_in_i),
        .en_16x_baud_i         (en_16x_baud_i),
        .read_buffer_i         (read_buffer_i),
        .reset_buffer_i        (reset_buffer_i),
        .data_out_o            (data_out_o),
        .err_out_o             (err_out_o),
        .buffer_level_o        (buffer_level_o),
        .buffer_data_present_o (buffer_data_present_o),
        .buffer_full_o         (buffer_full_o),
        .buffer_hfull_o        (buffer_hfull_o),
        .overrun_o             (overrun_o),
        .timeout_o             (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 16x baud tick: one clock high out of every TDIV, changed on negedge.
    initial begin
        int tcnt;
        tcnt = 0;
        en_16x_baud_i = 1'b0;
        forever begin
            @(negedge clk);
            tcnt = tcnt + 1;
            en_16x_baud_i = ((tcnt % TDIV) == 0);
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp = n_cmp + 1;
        assert (obs === expv) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_bits(input int n);
        wait_clks(n * BITCLK);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [2:0] e);
        exp_t x;
        x.d = d;
        x.e = e;
        if (exp_q.size() < DEPTH) exp_q.push_back(x);
        else exp_ovr = 1'b1;
    endtask

    // Drive one frame with the current configuration (start level = 0).
    task automatic send(input logic [7:0] d, input logic par_flip);
        int         n;
        logic [7:0] mask;
        logic [7:0] dm;
        logic       p;
        n    = 5 + int'(data_bits_i);
        mask = 8'((16'd1 << n) - 1);
        dm   = d & mask;
        push_exp(dm, {2'b00, par_flip & parity_en_i});
        serial_in_i = 1'b0;
        wait_bits(1);
        for (int k = 0; k < n; k++) begin
            serial_in_i = msb_first_i ? dm[n-1-k] : dm[k];
            wait_bits(1);
        end
        if (parity_en_i) begin
            p = (^dm) ^ parity_odd_i ^ par_flip;
            serial_in_i = p;
            wait_bits(1);
        end
        serial_in_i = 1'b1;
        wait_bits(1);
    endtask

    task automatic pulse_read();
        read_buffer_i = 1'b1;
        @(negedge clk);
        read_buffer_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_check(input string tag);
        exp_t x;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 16'd1, 16'd0);
        end else begin
            x = exp_q.pop_front();
            chk({tag, "_present"}, 16'(buffer_data_present_o), 16'd1);
            chk({tag, "_data"},    16'(data_out_o),            16'(x.d));
            chk({tag, "_err"},     16'(err_out_o),             16'(x.e));
            pulse_read();
        end
    endtask

    task automatic set_cfg(input logic msb, input logic pen, input logic podd, input logic [1:0] db);
        msb_first_i  = msb;
        parity_en_i  = pen;
        parity_odd_i = podd;
        data_bits_i  = db;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_ovr = 1'b0;
        rst = 1'b1;
        serial_in_i = 1'b1;
        start_polarity_i = 1'b0;
        read_buffer_i = 1'b0;
        reset_buffer_i = 1'b0;
        set_cfg(1'b0, 1'b0, 1'b0, 2'b11);
        wait_clks(5);

        // Reset state
        chk("rst_data",    16'(data_out_o),            16'd0);
        chk("rst_err",     16'(err_out_o),             16'd0);
        chk("rst_level",   16'(buffer_level_o),        16'd0);
        chk("rst_present", 16'(buffer_data_present_o), 16'd0);
        chk("rst_full",    16'(buffer_full_o),         16'd0);
        chk("rst_hfull",   16'(buffer_hfull_o),        16'd0);
        chk("rst_overrun", 16'(overrun_o),             16'd0);
        chk("rst_timeout", 16'(timeout_o),             16'd0);
        rst = 1'b0;
        wait_bits(3);
        chk("idle_level", 16'(buffer_level_o), 16'd0);

        // Read while empty is ignored
        pulse_read();
        chk("rd_empty_level", 16'(buffer_level_o), 16'd0);

        // 8N1 LSB first, 0xA5
        send(8'hA5, 1'b0);
        wait_clks(2);
        chk("a5_level", 16'(buffer_level_o), 16'd1);
        pop_check("a5");
        chk("a5_level_after", 16'(buffer_level_o), 16'd0);

        // 7E1 MSB first, 0x55 with wrong parity
        set_cfg(1'b1, 1'b1, 1'b0, 2'b10);
        send(8'h55, 1'b1);
        wait_clks(2);
        pop_check("par7");

        // 6 bits, odd parity, LSB first, good parity
        set_cfg(1'b0, 1'b1, 1'b1, 2'b01);
        send(8'h2D, 1'b0);
        wait_clks(2);
        pop_check("odd6");

        // Break: line at start level for 12 bit times, 8N1
        set_cfg(1'b0, 1'b0, 1'b0, 2'b11);
        push_exp(8'h00, 3'b110);
        serial_in_i = 1'b0;
        wait_bits(12);
        serial_in_i = 1'b1;
        wait_bits(3);
        chk("brk_level", 16'(buffer_level_o), 16'd1);
        pop_check("brk");

        // Glitch of 4 ticks rejected, then 0x3C received
        serial_in_i = 1'b0;
        wait_clks(4 * TDIV);
        serial_in_i = 1'b1;
        wait_bits(2);
        chk("glitch_level", 16'(buffer_level_o), 16'd0);
        send(8'h3C, 1'b0);
        wait_clks(2);
        chk("post_glitch_level", 16'(buffer_level_o), 16'd1);
        pop_check("post_glitch");

        // Fill: 17 characters without reads
        for (int i = 0; i < DEPTH + 1; i++) begin
            send(8'(i * 7 + 3), 1'b0);
            wait_clks(2);
            chk($sformatf("fill%0d_level", i),   16'(buffer_level_o), 16'(exp_q.size()));
            chk($sformatf("fill%0d_hfull", i),   16'(buffer_hfull_o), 16'(exp_q.size() >= DEPTH / 2));
            chk($sformatf("fill%0d_full", i),    16'(buffer_full_o),  16'(exp_q.size() == DEPTH));
            chk($sformatf("fill%0d_overrun", i), 16'(overrun_o),      16'(exp_ovr));
        end
        for (int i = 0; i < DEPTH; i++) begin
            pop_check($sformatf("drain%0d", i));
        end
        chk("drain_level",   16'(buffer_level_o), 16'd0);
        chk("drain_overrun", 16'(overrun_o),      16'd1);
        reset_buffer_i = 1'b1;
        @(negedge clk);
        reset_buffer_i = 1'b0;
        exp_ovr = 1'b0;
        chk("rstbuf_overrun", 16'(overrun_o), 16'd0);

        // reset_buffer_i discards stored entries
        send(8'h81, 1'b0);
        wait_clks(2);
        chk("rstbuf_pre_level", 16'(buffer_level_o), 16'd1);
        reset_buffer_i = 1'b1;
        @(negedge clk);
        reset_buffer_i = 1'b0;
        void'(exp_q.pop_front());
        chk("rstbuf_level", 16'(buffer_level_o), 16'd0);

        // Idle timeout after one character
        send(8'h5A, 1'b0);
        wait_clks(2);
        wait_clks(600 * TDIV);
        chk("to_early", 16'(timeout_o), 16'd0);
        wait_clks(100 * TDIV);
`ifdef UART_RX_TIMEOUT_EN
        chk("to_set", 16'(timeout_o), 16'd1);
`else
        chk("to_tied", 16'(timeout_o), 16'd0);
`endif
        pop_check("to_char");
        chk("to_cleared", 16'(timeout_o), 16'd0);

        // Asynchronous reset takes effect between clock edges
        send(8'h77, 1'b0);
        wait_clks(2);
        chk("ar_pre_present", 16'(buffer_data_present_o), 16'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_present", 16'(buffer_data_present_o), 16'd0);
        chk("ar_level",   16'(buffer_level_o),        16'd0);
        chk("ar_data",    16'(data_out_o),            16'd0);
        exp_q.delete();
        wait_clks(2);
        rst = 1'b0;
        wait_clks(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_ext.md
UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 Parameter FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries.
REQ-002 Parameter TIMEOUT_CHARS, 4, idle character times before timeout_o asserts.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 msb_first_i  input  1  0: LSB first; 1: MSB first.
REQ-006 parity_en_i  input  1  1: parity bit present after data.
REQ-007 parity_odd_i  input  1  0: even parity; 1: odd parity.
REQ-008 data_bits_i  input  2  00/01/10/11 = 5/6/7/8 data bits.
REQ-009 start_polarity_i  input  1  0: low start, high stop/idle; 1: inverse.
REQ-010 serial_in_i  input  1  asynchronous serial line.
REQ-011 en_16x_baud_i  input  1  one-clk tick at 16x baud.
REQ-012 read_buffer_i  input  1  pop FIFO head.
REQ-013 reset_buffer_i  input  1  synchronous FIFO/flag clear.
REQ-014 data_out_o  output  8  FIFO head data, right-justified, unused MSBs 0.
REQ-015 err_out_o  output  3  FIFO head flags {break, framing, parity}.
REQ-016 buffer_level_o  output  FIFO_AW+1  entry count.
REQ-017 buffer_data_present_o / buffer_full_o / buffer_hfull_o  output  1 each  level>0 / level==depth / level>=depth/2.
REQ-018 overrun_o  output  1  sticky: character dropped on full FIFO.
REQ-019 timeout_o  output  1  receive idle timeout.

Function
REQ-020 serial_in_i SHALL pass a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-021 FSM states IDLE, START, DATA, PARITY, STOP; tick counter 0..15 advances only on en_16x_baud_i.
REQ-022 IDLE->START on a tick with line at start level; START samples at count 7; line not at start level -> IDLE (glitch rejected, nothing written).
REQ-023 DATA samples every 16 ticks after START mid-point, N bits per data_bits_i; LSB-first bit k -> data[k], MSB-first first bit -> data[N-1].
REQ-024 PARITY (only if parity_en_i) samples one bit; parity error = XOR(data bits, parity bit, parity_odd_i) != 0.
REQ-025 STOP samples once at mid-bit; framing error if not stop level; FSM returns to IDLE in the same cycle (start of next character detectable on next tick).
REQ-026 Break: all data, parity and stop samples at start level -> break flag=1, data stored as 0, framing flag=1.
REQ-027 Character written to FIFO on the clk edge following the stop-bit sample; buffer_data_present_o rises the next cycle.
REQ-028 data_out_o/err_out_o are first-word fall-through (valid whenever buffer_data_present_o=1).
REQ-029 Read when empty ignored; write when full (no simultaneous read) dropped and overrun_o set.
REQ-030 Simultaneous read and write: full -> both performed, level unchanged, no overrun; empty -> write only.
REQ-031 Pointers wrap modulo depth; level never exceeds depth.
REQ-032 reset_buffer_i empties FIFO and clears overrun_o and timeout_o; receiver FSM unaffected; a write in the same cycle is discarded.
REQ-033 Configuration inputs SHALL be changed only while FSM is IDLE; otherwise behaviour is undefined for the current character only.

Reset
REQ-034 rst SHALL asynchronously force FSM IDLE, counters 0, FIFO empty, synchronizer flops 1, all outputs 0.
REQ-035 A false start caused by synchronizer reset value SHALL be rejected by REQ-022.

Configuration
REQ-036 Macro UART_RX_TIMEOUT_EN defined: tick counter runs while FSM IDLE and FIFO non-empty, clears on write, read or reset_buffer_i; reaching TIMEOUT_CHARS*160 ticks sets timeout_o until next read, write or reset_buffer_i.
REQ-037 Macro undefined: timeout_o tied 0, no counter logic.

Verification
REQ-038 8N1 LSB-first, byte 0xA5 -> data_out_o=0xA5, err_out_o=000, buffer_level_o=1.
REQ-039 7 bits, even parity, MSB-first, 0x55 with wrong parity bit -> data_out_o=0x55, err_out_o=001.
REQ-040 Line held at start level 12 bit times -> one entry, data 0x00, err_out_o=110.
REQ-041 Depth 16, 17 characters without reads -> level 16, overrun_o=1; 16 reads return first 16 in order.
REQ-042 Start pulse 4 ticks wide -> no write, FSM IDLE; following valid 0x3C received correctly.
REQ-043 With UART_RX_TIMEOUT_EN, one char then idle 640 ticks -> timeout_o=1; read -> timeout_o=0.
